// File: rtl/sha256d_nonce_sweep.sv
// rtl/sha256d_nonce_sweep.sv - job-driven 80-byte header source sweeping the nonce field for the sha256d pipeline
module sha256d_nonce_sweep #(
    parameter int unsigned STRIDE = 1,
    parameter int unsigned CNT_W  = 33
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [639:0]     job_data,
    input  logic [31:0]      job_nonce_start,
    input  logic [CNT_W-1:0] job_nonce_count,
    input  logic             job_vld,
    output logic             job_rdy,
    input  logic             pause,
    input  logic             abort,
    output logic [639:0]     out_data,
    output logic             out_vld,
    output logic             busy,
    output logic             done
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    localparam logic [31:0]      STEP = 32'(STRIDE);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    state_t             state_q;
    state_t             state_d;
    logic [607:0]       tmpl_q;
    logic [31:0]        nonce_q;
    logic [CNT_W-1:0]   rem_q;
    logic               rem_zero;

    // The template's own nonce bytes are always replaced by the sweep value.
    logic unused_job_nonce_bits;
    assign unused_job_nonce_bits = ^job_data[639:608];

    assign rem_zero = (rem_q == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (job_vld) state_d = S_RUN;
            S_RUN:  if (abort || rem_zero) state_d = S_IDLE;
        endcase
    end

    always_comb begin
        job_rdy = (state_q == S_IDLE);
        busy    = (state_q == S_RUN);
    end

    // Abort outranks completion so a cancelled job never reports done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmpl_q   <= '0;
            nonce_q  <= '0;
            rem_q    <= '0;
            out_data <= '0;
            out_vld  <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    out_vld <= 1'b0;
                    if (job_vld) begin
                        tmpl_q  <= job_data[607:0];
                        nonce_q <= job_nonce_start;
                        rem_q   <= job_nonce_count;
                    end
                end
                S_RUN: begin
                    if (abort) begin
                        out_vld <= 1'b0;
                        rem_q   <= '0;
                    end else if (rem_zero) begin
                        done    <= 1'b1;
                        out_vld <= 1'b0;
                    end else if (pause) begin
                        out_vld <= 1'b0;
                    end else begin
                        out_vld  <= 1'b1;
                        out_data <= {nonce_q, tmpl_q};
                        nonce_q  <= nonce_q + STEP;
                        rem_q    <= rem_q - ONE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sha256d_nonce_sweep.sv
// tb/tb_sha256d_nonce_sweep.sv - scoreboard bench driving stride-1 and stride-4 instances with shared jobs
module tb_sha256d_nonce_sweep;

    typedef logic [640:0] ev_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [639:0] job_data;
    logic [31:0]  job_nonce_start;
    logic [32:0]  job_nonce_count;
    logic         job_vld;
    logic         pause;
    logic         abort;

    logic [639:0] o_data [2];
    logic         o_vld  [2];
    logic         o_busy [2];
    logic         o_done [2];
    logic         o_rdy  [2];

    ev_t          expq [2][$];
    int           tests = 0;
    int           fails = 0;

    always #5 clk = ~clk;

    sha256d_nonce_sweep #(.STRIDE(1), .CNT_W(33)) dut1 (
        .clk(clk), .rst_n(rst_n), .job_data(job_data), .job_nonce_start(job_nonce_start),
        .job_nonce_count(job_nonce_count), .job_vld(job_vld), .job_rdy(o_rdy[0]),
        .pause(pause), .abort(abort), .out_data(o_data[0]), .out_vld(o_vld[0]),
        .busy(o_busy[0]), .done(o_done[0])
    );

    sha256d_nonce_sweep #(.STRIDE(4), .CNT_W(33)) dut4 (
        .clk(clk), .rst_n(rst_n), .job_data(job_data), .job_nonce_start(job_nonce_start),
        .job_nonce_count(job_nonce_count), .job_vld(job_vld), .job_rdy(o_rdy[1]),
        .pause(pause), .abort(abort), .out_data(o_data[1]), .out_vld(o_vld[1]),
        .busy(o_busy[1]), .done(o_done[1])
    );

    task automatic chk(input string name, input logic [639:0] act, input logic [639:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    function automatic logic [639:0] rnd640();
        logic [639:0] r;
        for (int i = 0; i < 20; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [31:0] stride_of(input int k);
        return (k == 0) ? 32'd1 : 32'd4;
    endfunction

    // Reference: a job emits {start + i*stride mod 2^32, template} for each i, then done.
    task automatic push_job(input logic [31:0] start, input logic [639:0] tmpl,
                            input longint nwords, input bit with_done);
        for (int k = 0; k < 2; k++) begin
            for (longint i = 0; i < nwords; i++) begin
                logic [31:0] n;
                n = start + 32'(i) * stride_of(k);
                expq[k].push_back({1'b0, n, tmpl[607:0]});
            end
            if (with_done) expq[k].push_back({1'b1, 640'd0});
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            for (int k = 0; k < 2; k++) begin
                if (o_vld[k]) begin
                    if (expq[k].size() == 0 || expq[k][0][640]) begin
                        tests++; fails++;
                        $display("FAIL unexpected_word inst%0d: got %h required no word", k, o_data[k]);
                    end else begin
                        ev_t ev;
                        ev = expq[k].pop_front();
                        chk($sformatf("word_inst%0d", k), o_data[k], ev[639:0]);
                    end
                end
                if (o_done[k]) begin
                    tests++;
                    if (expq[k].size() == 0 || !expq[k][0][640]) begin
                        fails++;
                        $display("FAIL unexpected_done inst%0d: got done=1 required pending=%0d words", k, expq[k].size());
                    end else begin
                        void'(expq[k].pop_front());
                    end
                end
            end
        end
    end

    // pmode: 0 none, 1 random pause, 2 two-cycle pause after the 2nd word.
    task automatic run_job(input logic [31:0] start, input logic [32:0] count, input logic [639:0] tmpl,
                           input int pmode, input int abort_at, input bit probe_ignore);
        longint cnt, nw, stalls, e, done_e, bound;
        int     p2left;
        bit     aborted;
        cnt = longint'(count);
        push_job(start, tmpl, (abort_at >= 0) ? longint'(abort_at) : cnt, abort_at < 0);
        @(posedge clk); #1;
        job_data = tmpl; job_nonce_start = start; job_nonce_count = count; job_vld = 1'b1;
        chk("job_rdy_before_accept", {639'd0, o_rdy[0]}, 640'd1);
        @(posedge clk); #1;
        job_vld = 1'b0; job_data = rnd640(); job_nonce_start = $urandom; job_nonce_count = 33'($urandom);
        e = 0; nw = 0; stalls = 0; done_e = -1; p2left = 2; aborted = 0; bound = cnt + 300;
        while (o_busy[0] && e < bound) begin
            pause = 1'b0; abort = 1'b0;
            if (abort_at >= 0 && nw == abort_at && !aborted) begin
                abort = 1'b1; aborted = 1;
            end else if (pmode == 1) begin
                pause = ($urandom_range(0, 2) == 0);
            end else if (pmode == 2 && nw >= 2 && p2left > 0) begin
                pause = 1'b1; p2left--;
            end
            if (probe_ignore) begin
                job_vld = $urandom_range(0, 1);
                job_data = rnd640(); job_nonce_start = $urandom;
            end
            if (pause && nw < cnt) stalls++;
            @(posedge clk); e++; #1;
            if (o_vld[0]) nw++;
            if (o_done[0]) done_e = e;
        end
        pause = 1'b0; abort = 1'b0; job_vld = 1'b0;
        if (e >= bound) begin
            tests++; fails++;
            $display("FAIL timeout: busy still high after %0d cycles, required idle", e);
        end
        if (abort_at >= 0) begin
            chk("abort_words", 640'(nw), 640'(abort_at));
            chk("abort_no_done", 640'(done_e), 640'(-64'sd1));
            chk("abort_vld_low", {639'd0, o_vld[0]}, 640'd0);
            chk("abort_rdy", {638'd0, o_rdy[1], o_rdy[0]}, 640'd3);
        end else begin
            chk("word_count", 640'(nw), 640'(cnt));
            chk("done_edge", 640'(done_e), 640'(cnt + 1 + stalls));
        end
        @(negedge clk); #1;
        chk("scoreboard_drained", 640'(expq[0].size() + expq[1].size()), 640'd0);
    endtask

    initial begin
        logic [607:0] hdr_be;
        logic [639:0] hdr;
        rst_n = 1'b0; job_vld = 1'b0; pause = 1'b0; abort = 1'b0;
        job_data = '0; job_nonce_start = '0; job_nonce_count = '0;

        #3;
        for (int k = 0; k < 2; k++)
            chk($sformatf("reset_outputs_inst%0d", k),
                {635'd0, o_vld[k], o_done[k], o_busy[k], o_rdy[k], |o_data[k]}, 640'b00010);
        pause = 1'b1; abort = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("after_release", {636'd0, o_vld[0], o_done[0], o_busy[0], o_rdy[0]}, 640'b0001);
        pause = 1'b0; abort = 1'b0;

        // Block 125552 header, bytes in wire order, byte 0 first.
        hdr_be = {32'h01000000,
                  128'h81cd02ab7e569e8bcd9317e2fe99f2de, 128'h44d49ab2b8851ba4a308000000000000,
                  128'he320b6c2fffc8d750423db8b1eb942ae, 128'h710e951ed797f7affc8892b0f1fc122b,
                  32'hc7f5d74d, 32'hf2b9441a};
        hdr = rnd640();
        for (int j = 0; j < 76; j++) hdr[8*j +: 8] = hdr_be[607 - 8*j -: 8];
        run_job(32'h9546A140, 33'd4, hdr, 0, -1, 0);

        run_job(32'hFFFFFFFE, 33'd3, rnd640(), 0, -1, 0);
        run_job(32'hFFFFFFFC, 33'd2, rnd640(), 0, -1, 0);
        run_job($urandom, 33'd5, rnd640(), 2, -1, 0);
        run_job($urandom, 33'd100, rnd640(), 0, 10, 1);
        run_job($urandom, 33'd1, rnd640(), 0, -1, 0);
        run_job($urandom, 33'd0, rnd640(), 1, -1, 0);
        for (int t = 0; t < 8; t++)
            run_job($urandom, 33'($urandom_range(0, 7)), rnd640(), 1, -1, 0);

        // Reset in the middle of a running job.
        push_job(32'h12345678, rnd640(), 3, 0);
        begin
            logic [639:0] tm;
            int nw, guard;
            tm = rnd640();
            expq[0].delete(); expq[1].delete();
            push_job(32'h12345678, tm, 3, 0);
            @(posedge clk); #1;
            job_data = tm; job_nonce_start = 32'h12345678; job_nonce_count = 33'd40; job_vld = 1'b1;
            @(posedge clk); #1 job_vld = 1'b0;
            nw = 0; guard = 0;
            while (nw < 3 && guard < 50) begin
                @(posedge clk); #1; guard++;
                if (o_vld[0]) nw++;
            end
            @(negedge clk); #1;
            rst_n = 1'b0; #1;
            for (int k = 0; k < 2; k++)
                chk($sformatf("midrun_reset_inst%0d", k),
                    {635'd0, o_vld[k], o_done[k], o_busy[k], o_rdy[k], |o_data[k]}, 640'b00010);
            chk("midrun_words_seen", 640'(expq[0].size() + expq[1].size()), 640'd0);
            expq[0].delete(); expq[1].delete();
            repeat (2) @(posedge clk);
            #1 rst_n = 1'b1;
        end
        run_job(32'h00000010, 33'd3, rnd640(), 0, -1, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
